// File: rtl/led_pkg.sv
// led_pkg: mode encodings, per-mode pattern lengths and the LED pattern lookup
// shared by the LED pattern sequencer and its bench.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_BLINK  = 2'd0,
        MODE_ALT    = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_t;

    localparam int LEN_BLINK  = 2;
    localparam int LEN_ALT    = 2;
    localparam int LEN_CHASE  = 3;
    localparam int LEN_BOUNCE = 4;

    // Index of the last step of a mode; the step counter wraps to 0 after it.
    function automatic logic [1:0] last_step(input mode_t mode);
        logic [1:0] last;
        last = 2'd0;
        case (mode)
            MODE_BLINK:  last = 2'(LEN_BLINK - 1);
            MODE_ALT:    last = 2'(LEN_ALT - 1);
            MODE_CHASE:  last = 2'(LEN_CHASE - 1);
            MODE_BOUNCE: last = 2'(LEN_BOUNCE - 1);
            default:     last = 2'd0;
        endcase
        return last;
    endfunction

    // {LED2,LED1,LED0} for a given mode and step. Out-of-range steps give 000.
    function automatic logic [2:0] pattern(input mode_t mode, input logic [1:0] step);
        logic [2:0] p;
        p = 3'b000;
        case (mode)
            MODE_BLINK: begin
                case (step)
                    2'd0:    p = 3'b111;
                    default: p = 3'b000;
                endcase
            end
            MODE_ALT: begin
                case (step)
                    2'd0:    p = 3'b101;
                    2'd1:    p = 3'b010;
                    default: p = 3'b000;
                endcase
            end
            MODE_CHASE: begin
                case (step)
                    2'd0:    p = 3'b001;
                    2'd1:    p = 3'b010;
                    2'd2:    p = 3'b100;
                    default: p = 3'b000;
                endcase
            end
            MODE_BOUNCE: begin
                case (step)
                    2'd0:    p = 3'b001;
                    2'd1:    p = 3'b010;
                    2'd2:    p = 3'b100;
                    default: p = 3'b010;
                endcase
            end
            default: p = 3'b000;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer, stability counter and rising-edge
// detector for a bouncy active-high push-button. PRESS is a one-cycle pulse
// per debounced rise; a debounced fall produces nothing.
module btn_debounce #(
    parameter int DB_CYCLES = 500000,
    parameter int DB_W      = 19
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN,
    output logic PRESS
);

    logic            s1;
    logic            s2;
    logic [DB_W-1:0] db_cnt;
    logic            db_level;
    logic            db_level_q;

    // Bring the asynchronous button into the CLK domain.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= BTN;
            s2 <= s1;
        end
    end

    // Accept a new level only after DB_CYCLES consecutive disagreeing samples;
    // any sample that agrees with the current level restarts the count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            db_cnt   <= '0;
            db_level <= 1'b0;
        end else if (s2 != db_level) begin
            if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
                db_level <= s2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    // Delayed copy of the debounced level for edge detection.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            db_level_q <= 1'b0;
        end else begin
            db_level_q <= db_level;
        end
    end

    assign PRESS = db_level & ~db_level_q;

endmodule

// File: rtl/led_pattern_seq.sv
// led_pattern_seq: drives LED0..LED2 with one of four patterns, stepped by the
// divider TICK and selected by a debounced push-button.
// Optional build macro LED_PAUSE_EN adds a PAUSE input that freezes stepping.
module led_pattern_seq
    import led_pkg::*;
#(
    parameter int DB_CYCLES = 500000,
    parameter int DB_W      = 19
) (
    input  logic CLK,
    input  logic RST,
    input  logic TICK,
    input  logic BTN,
`ifdef LED_PAUSE_EN
    input  logic PAUSE,
`endif
    output logic LED0,
    output logic LED1,
    output logic LED2
);

    mode_t      mode;
    mode_t      mode_nxt;
    logic [1:0] step;
    logic [1:0] step_nxt;
    logic [2:0] led_q;
    logic       press;
    logic       tick_en;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .DB_W      (DB_W)
    ) u_debounce (
        .CLK   (CLK),
        .RST   (RST),
        .BTN   (BTN),
        .PRESS (press)
    );

`ifdef LED_PAUSE_EN
    assign tick_en = TICK & ~PAUSE;
`else
    assign tick_en = TICK;
`endif

    // Next mode/step: a press takes priority and drops a simultaneous tick.
    always_comb begin
        mode_nxt = mode;
        step_nxt = step;
        if (press) begin
            mode_nxt = mode_t'(mode + 2'd1);
            step_nxt = 2'd0;
        end else if (tick_en) begin
            step_nxt = (step == last_step(mode)) ? 2'd0 : step + 2'd1;
        end
    end

    // Mode and step registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode <= MODE_BLINK;
            step <= 2'd0;
        end else begin
            mode <= mode_nxt;
            step <= step_nxt;
        end
    end

    // Registered LED outputs, one cycle behind mode/step.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            led_q <= 3'b000;
        end else begin
            led_q <= pattern(mode, step);
        end
    end

    assign LED0 = led_q[0];
    assign LED1 = led_q[1];
    assign LED2 = led_q[2];

endmodule

// File: tb/tb_led_pattern_seq.sv
// tb_led_pattern_seq: vector-table bench for led_pattern_seq with a short
// debounce window (DB_CYCLES=4). Inputs change on the falling edge, LEDs are
// sampled 1 time unit after the rising edge.
module tb_led_pattern_seq;

    logic CLK;
    logic RST;
    logic TICK;
    logic BTN;
`ifdef LED_PAUSE_EN
    logic PAUSE;
`endif
    logic LED0;
    logic LED1;
    logic LED2;

    typedef struct {
        logic       tick;
        logic       btn;
        logic       chk;
        logic [2:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [2:0] exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    led_pattern_seq #(
        .DB_CYCLES (4),
        .DB_W      (3)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .TICK  (TICK),
        .BTN   (BTN),
`ifdef LED_PAUSE_EN
        .PAUSE (PAUSE),
`endif
        .LED0  (LED0),
        .LED1  (LED1),
        .LED2  (LED2)
    );

    // Clock and watchdog
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("[TB] watchdog expired, simulation stopped");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int idx,
                         input logic [2:0] act, input logic [2:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: LED=%b expected %b", name, idx, act, exp);
        end
    endtask

    // Table helpers: checked and unchecked cycles
    task automatic add(input logic t, input logic b, input logic [2:0] e);
        vec_t v;
        v.tick = t; v.btn = b; v.chk = 1'b1; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic addx(input logic t, input logic b);
        vec_t v;
        v.tick = t; v.btn = b; v.chk = 1'b0; v.exp = 3'b000;
        vecs.push_back(v);
    endtask

    // Apply the table one cycle per entry; expected LEDs go through the queue.
    task automatic run_vecs(input string name);
        logic [2:0] e;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            TICK = vecs[i].tick;
            BTN  = vecs[i].btn;
            if (vecs[i].chk) exp_q.push_back(vecs[i].exp);
            @(posedge CLK);
            #1;
            if (vecs[i].chk) begin
                e = exp_q.pop_front();
                check(name, i, {LED2, LED1, LED0}, e);
            end
        end
        vecs.delete();
    endtask

    // Asynchronous reset between edges, held across one edge, released after an edge.
    task automatic do_reset(input string name);
        @(negedge CLK);
        #1;
        RST  = 1'b1;
        TICK = 1'b0;
        BTN  = 1'b0;
        #1;
        check({name, "_async"}, 0, {LED2, LED1, LED0}, 3'b000);
        @(posedge CLK);
        #1;
        check({name, "_hold"}, 0, {LED2, LED1, LED0}, 3'b000);
        #1;
        RST = 1'b0;
    endtask

    // Full press and release with no ticks; ends with one check of the new step-0 pattern.
    task automatic press_mode(input string name, input logic [2:0] e);
        for (int i = 0; i < 8; i++) addx(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) addx(1'b0, 1'b0);
        add(1'b0, 1'b0, e);
        run_vecs(name);
    endtask

    initial begin
        RST  = 1'b0;
        TICK = 1'b0;
        BTN  = 1'b0;
`ifdef LED_PAUSE_EN
        PAUSE = 1'b0;
`endif
        repeat (2) @(posedge CLK);

        // 1: reset and BLINK stepping
        do_reset("rst0");
        add(0, 0, 3'b111); add(1, 0, 3'b111); add(0, 0, 3'b000);
        add(0, 0, 3'b000); add(1, 0, 3'b000); add(0, 0, 3'b111);
        run_vecs("blink");

        // 2: held button -> one mode change to ALT, tick, hold, release
        for (int i = 0; i < 7; i++) add(0, 1, 3'b111);
        for (int i = 0; i < 3; i++) add(0, 1, 3'b101);
        add(1, 1, 3'b101);
        for (int i = 0; i < 5; i++) add(0, 1, 3'b010);
        for (int i = 0; i < 8; i++) add(0, 0, 3'b010);
        run_vecs("press_hold");

        // 3: glitch one sample short of the debounce window, ticks keep running
        do_reset("rst1");
        add(0, 0, 3'b111);
        add(1, 1, 3'b111); add(0, 1, 3'b000); add(1, 1, 3'b000); add(0, 0, 3'b111);
        for (int i = 0; i < 6; i++) add(0, 0, 3'b111);
        add(1, 0, 3'b111); add(0, 0, 3'b000);
        run_vecs("glitch");

        // 4: ALT -> CHASE sequence -> BOUNCE sequence
        press_mode("to_alt", 3'b101);
        press_mode("to_chase", 3'b001);
        add(1, 0, 3'b001); add(1, 0, 3'b010); add(1, 0, 3'b100);
        add(1, 0, 3'b001); add(0, 0, 3'b010);
        run_vecs("chase");
        press_mode("to_bounce", 3'b001);
        add(1, 0, 3'b001); add(1, 0, 3'b010); add(1, 0, 3'b100);
        add(1, 0, 3'b010); add(1, 0, 3'b001); add(0, 0, 3'b010);
        run_vecs("bounce");

        // 5: press pulse coincides with TICK in BOUNCE step 1 -> BLINK step 0
        for (int i = 0; i < 6; i++) add(0, 1, 3'b010);
        add(1, 1, 3'b010);
        add(0, 1, 3'b111); add(0, 1, 3'b111); add(0, 1, 3'b111);
        for (int i = 0; i < 8; i++) add(0, 0, 3'b111);
        run_vecs("collide");

        // 6: reset in CHASE step 2
        press_mode("to_alt2", 3'b101);
        press_mode("to_chase2", 3'b001);
        add(1, 0, 3'b001); add(1, 0, 3'b010); add(0, 0, 3'b100);
        run_vecs("chase2");
        do_reset("rst_mid");
        add(0, 0, 3'b111); add(1, 0, 3'b111); add(0, 0, 3'b000);
        run_vecs("after_rst");

`ifdef LED_PAUSE_EN
        // 7: pause freezes stepping, presses still act
        PAUSE = 1'b1;
        add(1, 0, 3'b000); add(1, 0, 3'b000); add(1, 0, 3'b000); add(0, 0, 3'b000);
        run_vecs("paused");
        press_mode("pause_press", 3'b101);
        add(1, 0, 3'b101); add(1, 0, 3'b101);
        run_vecs("paused_alt");
        PAUSE = 1'b0;
        add(1, 0, 3'b101); add(0, 0, 3'b010);
        run_vecs("unpaused");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
